ram_delay_ctrl: RTL
===================

Name: ram_delay_ctrl

Overview:
Sequencing and configuration controller for one RAM delay line. It owns the delay line's write strobe, external address bus, delay length and flush. It accepts delay-length change requests over a req/ack handshake and applies them only at a buffer wrap boundary. It then re-primes the line and reports when the delayed output is usable.

Parameters:
P_NBITS_ADDR, 8, width of address and delay length
P_N_DEFAULT, 16, delay length loaded at reset (must be >= 2 and <= 2**P_NBITS_ADDR-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s_stb  input  1  input sample strobe (one sample per asserted cycle)
cfg_req  input  1  delay change request, level, held until cfg_ack or cfg_err
cfg_n  input  P_NBITS_ADDR  requested delay length, stable while cfg_req high
cfg_ack  output  1  one-cycle pulse: new length applied
cfg_err  output  1  one-cycle pulse: request rejected (cfg_n < 2)
dl_wr  output  1  write strobe to delay line
dl_addr_en  output  1  external address enable to delay line
dl_addr  output  P_NBITS_ADDR  write address to delay line
dl_n  output  P_NBITS_ADDR  active delay length to delay line
dl_flush  output  1  flush to delay line
dl_valid  input  1  valid from delay line
ready  output  1  delayed output usable
state_o  output  2  current state (0 PRIME, 1 RUN, 2 DRAIN)
busy  output  1  request pending (state DRAIN)

Behaviour:
- Reset (rst_n low, async):
  - state=PRIME, dl_n=P_N_DEFAULT, addr_cnt=0, prime_cnt=0.
  - dl_wr=0, dl_addr=0, dl_flush=1, dl_addr_en=1 (constant 1 at all times).
  - cfg_ack=0, cfg_err=0, ready=0, busy=0.
- Datapath timing:
  - dl_wr and dl_addr are registered: dl_wr <= s_stb; dl_addr <= addr_cnt when s_stb.
  - Latency from s_stb to dl_wr is 1 cycle. The integrator delays sample data by 1 cycle to align.
- Address counter:
  - addr_cnt advances only on s_stb.
  - Wraps from dl_n-1 to 0. A "wrap stb" is an s_stb with addr_cnt==dl_n-1.
- PRIME:
  - dl_flush=1.
  - prime_cnt increments per s_stb.
  - An s_stb with prime_cnt==dl_n-1 sets next state RUN and clears prime_cnt. That is exactly dl_n writes.
  - A valid cfg_req here is applied immediately: dl_n<=cfg_n, addr_cnt<=0, prime_cnt<=0, cfg_ack pulses next cycle, state stays PRIME.
  - If s_stb coincides with an applied request, that sample is written at addr 0 and counts as prime write 1.
- RUN:
  - dl_flush=0.
  - A valid cfg_req latches pend_n<=cfg_n and moves to DRAIN.
  - If that same cycle is a wrap stb, the length is applied immediately instead. See the apply rule below.
- DRAIN:
  - busy=1, dl_flush=0. Further cfg_req edges are not sampled; the held request is already owned.
  - On the wrap stb, the apply rule fires.
- Apply rule (from RUN wrap or DRAIN wrap):
  - That sample is written at old addr dl_n-1.
  - Next cycle: dl_n<=pend_n (or cfg_n), addr_cnt<=0, prime_cnt<=0, state PRIME, cfg_ack=1 for one cycle.
- Error path:
  - A request with cfg_n<2 in any state gives cfg_err=1 one cycle after sampling.
  - No other state change occurs.
  - The requester must drop cfg_req after ack or err. Controller re-samples cfg_req only after seeing it low for at least 1 cycle.
- ready:
  - ready = (state != PRIME) && dl_valid, combinational from registered state.
  - It drops in the cycle state enters PRIME.
- s_stb absent for long periods: all counters hold, no timeout.
- Reset mid-DRAIN: pending request discarded, no ack. dl_n returns to P_N_DEFAULT.
- dl_n is never changed except via the apply rule or reset, so the delay line never sees a mid-buffer length change.

Test Plan:
- Reset then 16 consecutive s_stb -> dl_addr 0..15, dl_flush 1 through 16th write, state RUN after 16th, then ready follows dl_valid.
- In RUN with addr_cnt=5, dl_n=16, cfg_req with cfg_n=10 -> busy=1, state DRAIN. Apply occurs on the stb writing addr 15, cfg_ack 1 cycle later, dl_n=10, next write addr 0. Then 10 prime writes, then RUN.
- cfg_req with cfg_n=1 in RUN -> cfg_err pulse, no ack, dl_n unchanged at 16, state RUN.
- cfg_req with cfg_n=4 during PRIME after 7 writes -> immediate apply, cfg_ack, addr restarts at 0. Exactly 4 further writes reach RUN.
- cfg_req asserted in the same cycle as a RUN wrap stb (addr 15), cfg_n=8 -> no DRAIN visit, cfg_ack next cycle, dl_n=8.
- rst_n low while in DRAIN with pend_n=8 -> no cfg_ack, dl_n=16, state PRIME, dl_flush=1, addr 0.

Source files
------------

// File: rtl/ram_delay_ctrl.sv
// Sequencing/configuration controller for one RAM delay line: owns write strobe,
// address, delay length and flush; applies length changes only at a buffer wrap.
module ram_delay_ctrl #(
    parameter int P_NBITS_ADDR = 8,
    parameter int P_N_DEFAULT  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_stb,
    input  logic                    cfg_req,
    input  logic [P_NBITS_ADDR-1:0] cfg_n,
    output logic                    cfg_ack,
    output logic                    cfg_err,
    output logic                    dl_wr,
    output logic                    dl_addr_en,
    output logic [P_NBITS_ADDR-1:0] dl_addr,
    output logic [P_NBITS_ADDR-1:0] dl_n,
    output logic                    dl_flush,
    input  logic                    dl_valid,
    output logic                    ready,
    output logic [1:0]              state_o,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [P_NBITS_ADDR-1:0] N_RST = P_NBITS_ADDR'(P_N_DEFAULT);
    localparam logic [P_NBITS_ADDR-1:0] ONE   = P_NBITS_ADDR'(1);
    localparam logic [P_NBITS_ADDR-1:0] TWO   = P_NBITS_ADDR'(2);

    state_t                  state_q, state_d;
    logic [P_NBITS_ADDR-1:0] dl_n_q, dl_n_d;
    logic [P_NBITS_ADDR-1:0] addr_cnt_q, addr_cnt_d;
    logic [P_NBITS_ADDR-1:0] prime_cnt_q, prime_cnt_d;
    logic [P_NBITS_ADDR-1:0] pend_n_q, pend_n_d;
    logic [P_NBITS_ADDR-1:0] dl_addr_q, dl_addr_d;
    logic                    dl_wr_q, dl_wr_d;
    logic                    cfg_ack_q, cfg_ack_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    armed_q, armed_d;

    logic [P_NBITS_ADDR-1:0] last_addr;
    logic                    wrap_stb;
    logic                    req_take;
    logic                    req_ok;

    assign last_addr = dl_n_q - ONE;
    assign wrap_stb  = s_stb && (addr_cnt_q == last_addr);
    // A held request is owned once taken; DRAIN never looks at cfg_req again.
    assign req_take  = cfg_req && armed_q && (state_q != S_DRAIN);
    assign req_ok    = (cfg_n >= TWO);

    always_comb begin
        state_d     = state_q;
        dl_n_d      = dl_n_q;
        addr_cnt_d  = addr_cnt_q;
        prime_cnt_d = prime_cnt_q;
        pend_n_d    = pend_n_q;
        dl_addr_d   = dl_addr_q;
        dl_wr_d     = s_stb;
        cfg_ack_d   = 1'b0;
        cfg_err_d   = 1'b0;
        armed_d     = armed_q;

        if (!cfg_req) begin
            armed_d = 1'b1;
        end else if (req_take) begin
            armed_d = 1'b0;
        end

        if (s_stb) begin
            dl_addr_d  = addr_cnt_q;
            addr_cnt_d = wrap_stb ? '0 : addr_cnt_q + ONE;
        end

        if (req_take && !req_ok) begin
            cfg_err_d = 1'b1;
        end

        case (state_q)
            S_PRIME: begin
                if (s_stb) begin
                    if (prime_cnt_q == last_addr) begin
                        state_d     = S_RUN;
                        prime_cnt_d = '0;
                    end else begin
                        prime_cnt_d = prime_cnt_q + ONE;
                    end
                end
                // Buffer holds nothing usable yet, so the new length applies at once;
                // a coincident sample becomes the first prime write at address 0.
                if (req_take && req_ok) begin
                    state_d     = S_PRIME;
                    dl_n_d      = cfg_n;
                    cfg_ack_d   = 1'b1;
                    addr_cnt_d  = s_stb ? ONE : '0;
                    prime_cnt_d = s_stb ? ONE : '0;
                    if (s_stb) begin
                        dl_addr_d = '0;
                    end
                end
            end
            S_RUN: begin
                if (req_take && req_ok) begin
                    if (wrap_stb) begin
                        state_d     = S_PRIME;
                        dl_n_d      = cfg_n;
                        addr_cnt_d  = '0;
                        prime_cnt_d = '0;
                        cfg_ack_d   = 1'b1;
                    end else begin
                        pend_n_d = cfg_n;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wrap_stb) begin
                    state_d     = S_PRIME;
                    dl_n_d      = pend_n_q;
                    addr_cnt_d  = '0;
                    prime_cnt_d = '0;
                    cfg_ack_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_PRIME;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PRIME;
            dl_n_q      <= N_RST;
            addr_cnt_q  <= '0;
            prime_cnt_q <= '0;
            pend_n_q    <= '0;
            dl_addr_q   <= '0;
            dl_wr_q     <= 1'b0;
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            dl_n_q      <= dl_n_d;
            addr_cnt_q  <= addr_cnt_d;
            prime_cnt_q <= prime_cnt_d;
            pend_n_q    <= pend_n_d;
            dl_addr_q   <= dl_addr_d;
            dl_wr_q     <= dl_wr_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_err_q   <= cfg_err_d;
            armed_q     <= armed_d;
        end
    end

    assign dl_wr      = dl_wr_q;
    assign dl_addr    = dl_addr_q;
    assign dl_addr_en = 1'b1;
    assign dl_n       = dl_n_q;
    assign dl_flush   = (state_q == S_PRIME);
    assign cfg_ack    = cfg_ack_q;
    assign cfg_err    = cfg_err_q;
    assign ready      = (state_q != S_PRIME) && dl_valid;
    assign state_o    = state_q;
    assign busy       = (state_q == S_DRAIN);

endmodule
